// File: rtl/ofdm_cp_remover_pkg.sv
// Shared types and constants for the OFDM cyclic-prefix remover.
package ofdm_cp_remover_pkg;

  typedef enum logic [1:0] {
    S_CP    = 2'd0,
    S_DATA  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [7:0] SR_CP_LEN_DEFAULT = 8'd6;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ofdm_cp_remover_setting_reg.sv
// Settings-bus register: captures set_data when a strobe hits its address.
module ofdm_cp_remover_setting_reg #(
  parameter int               WIDTH    = 8,
  parameter logic [7:0]       ADDR     = 8'd0,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [WIDTH-1:0] set_data,
  output logic [WIDTH-1:0] out
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out <= AT_RESET;
    end else if (set_stb && (set_addr == ADDR)) begin
      out <= set_data;
    end
  end

endmodule

// File: rtl/ofdm_cp_remover.sv
// Strips the cyclic prefix from framed OFDM symbols and emits FFT_LEN-sample packets.
module ofdm_cp_remover
  import ofdm_cp_remover_pkg::*;
#(
  parameter int         FFT_LEN   = 64,
  parameter int         CP_LEN    = 16,
  parameter logic [7:0] SR_CP_LEN = SR_CP_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [15:0] err_short,
  output logic [15:0] err_long
);

  // Wide enough for both the FFT sample index and the longest (255) prefix.
  localparam int CNT_W = ($clog2(FFT_LEN) + 1 > 8) ? $clog2(FFT_LEN) + 1 : 8;

  logic [7:0]       cp_len;
  logic [7:0]       cp_len_active;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             running;
  logic             in_data;
  logic             fft_last;
  logic             cp_last;
  logic             accept;
  logic             unused_set_data;

  ofdm_cp_remover_setting_reg #(
    .WIDTH    (8),
    .ADDR     (SR_CP_LEN),
    .AT_RESET (8'(CP_LEN))
  ) u_cp_len_reg (
    .clk      (clk),
    .aresetn  (aresetn),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data[7:0]),
    .out      (cp_len)
  );

  assign unused_set_data = ^set_data[31:8];

  // A zero-length prefix makes S_CP behave exactly like S_DATA.
  assign in_data  = (state == S_DATA) || ((state == S_CP) && (cp_len_active == 8'd0));
  assign fft_last = (cnt == CNT_W'(FFT_LEN - 1));
  assign cp_last  = (cnt == CNT_W'(cp_len_active) - CNT_W'(1));
  assign i_tready = running && (in_data ? (~o_tvalid | o_tready) : 1'b1);
  assign accept   = i_tvalid && i_tready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_CP;
      cnt           <= '0;
      cp_len_active <= 8'(CP_LEN);
      running       <= 1'b0;
      o_tvalid      <= 1'b0;
      o_tlast       <= 1'b0;
      o_tdata       <= '0;
      err_short     <= '0;
      err_long      <= '0;
    end else begin
      running <= 1'b1;
      if (clear) begin
        state         <= S_CP;
        cnt           <= '0;
        cp_len_active <= cp_len;
        o_tvalid      <= 1'b0;
        err_short     <= '0;
        err_long      <= '0;
      end else begin
        if (o_tvalid && o_tready) o_tvalid <= 1'b0;
        if (accept) begin
          if (in_data) begin
            o_tvalid <= 1'b1;
            o_tdata  <= i_tdata;
            o_tlast  <= fft_last || i_tlast;
            if (fft_last && !i_tlast) begin
              state    <= S_FLUSH;
              err_long <= sat_inc16(err_long);
            end else if (fft_last || i_tlast) begin
              if (!fft_last) err_short <= sat_inc16(err_short);
              state         <= S_CP;
              cnt           <= '0;
              cp_len_active <= cp_len;
            end else begin
              state <= S_DATA;
              cnt   <= cnt + CNT_W'(1);
            end
          end else if (state == S_FLUSH) begin
            if (i_tlast) begin
              state         <= S_CP;
              cnt           <= '0;
              cp_len_active <= cp_len;
            end
          end else begin
            if (i_tlast) begin
              err_short     <= sat_inc16(err_short);
              cnt           <= '0;
              cp_len_active <= cp_len;
            end else if (cp_last) begin
              state <= S_DATA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
      end
    end
  end

endmodule
